// File: rtl/guineveer_halt_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// guineveer_halt_ctrl_pkg
// Shared types for the VeeR EL2 halt/run/NMI command sequencer:
//   - op_e     : command op codes carried on cmd_op_i
//   - status_e : response codes returned on rsp_status_o
//   - state_e  : sequencer FSM states
//   - STATUS_W : width of the status field
//   - max3     : helper used to size the shared down-counter
// ----------------------------------------------------------------------------
package guineveer_halt_ctrl_pkg;

    localparam int STATUS_W = 2;

    typedef enum logic [1:0] {
        OP_HALT = 2'd0,
        OP_RUN  = 2'd1,
        OP_NMI  = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    typedef enum logic [STATUS_W-1:0] {
        ST_OK      = 2'd0,
        ST_TIMEOUT = 2'd1,
        ST_ILLEGAL = 2'd2
    } status_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HALT_WAIT = 3'd1,
        RUN_WAIT  = 3'd2,
        NMI_HI    = 3'd3,
        NMI_LO    = 3'd4,
        RESP      = 3'd5
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/guineveer_halt_ctrl.sv
// ----------------------------------------------------------------------------
// guineveer_halt_ctrl
// Command-driven sequencer for the VeeR EL2 halt/run handshake and NMI pulse.
// One command is accepted at a time; each command ends with a single-cycle
// status strobe. Every wait on the core is bounded by ACK_TIMEOUT, and the
// NMI pulse is shaped to NMI_HOLD cycles high followed by NMI_GAP cycles low.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o command handshake, cmd_op_i selects HALT/RUN/NMI
//   rsp_valid_o/rsp_status_o one-cycle status strobe (OK/TIMEOUT/ILLEGAL)
//   cpu_halt_req_o/cpu_halt_ack_i, cpu_run_req_o/cpu_run_ack_i core handshakes
//   cpu_halt_status_i       core halted status; core_halted_o is it registered
//   nmi_int_o               NMI pin to the core
// All outputs are registered.
// ----------------------------------------------------------------------------
module guineveer_halt_ctrl
    import guineveer_halt_ctrl_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1024,
    parameter int NMI_HOLD    = 2,
    parameter int NMI_GAP     = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [1:0]          cmd_op_i,
    output logic                rsp_valid_o,
    output logic [STATUS_W-1:0] rsp_status_o,
    output logic                cpu_halt_req_o,
    input  logic                cpu_halt_ack_i,
    input  logic                cpu_halt_status_i,
    output logic                cpu_run_req_o,
    input  logic                cpu_run_ack_i,
    output logic                nmi_int_o,
    output logic                core_halted_o
);

    // One down-counter serves the ack timeout and both NMI phases, so it is
    // sized for the largest reload value.
    localparam int CNT_MAX = max3(ACK_TIMEOUT, NMI_HOLD, NMI_GAP);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LOAD_ACK  = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] LOAD_HOLD = CNT_W'(NMI_HOLD);
    localparam logic [CNT_W-1:0] LOAD_GAP  = CNT_W'(NMI_GAP);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic [CNT_W-1:0] cnt_dec;

    // The counter holds the number of cycles left in the current phase;
    // the phase ends on the edge where it reads 1. Zero is treated the same
    // way so a corrupted value can never stall the FSM.
    assign cnt_last = (cnt <= CNT_W'(1));
    // Saturating decrement: never wraps below zero.
    assign cnt_dec  = (cnt == '0) ? '0 : cnt - CNT_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            cnt            <= '0;
            cmd_ready_o    <= 1'b0;
            rsp_valid_o    <= 1'b0;
            rsp_status_o   <= ST_OK;
            cpu_halt_req_o <= 1'b0;
            cpu_run_req_o  <= 1'b0;
            nmi_int_o      <= 1'b0;
            core_halted_o  <= 1'b0;
        end else begin
            core_halted_o <= cpu_halt_status_i;
            rsp_valid_o   <= 1'b0;

            case (state)
                IDLE: begin
                    cmd_ready_o <= 1'b1;
                    if (cmd_valid_i && cmd_ready_o) begin
                        cmd_ready_o <= 1'b0;
                        case (op_e'(cmd_op_i))
                            OP_HALT: begin
                                if (cpu_halt_status_i) begin
                                    // Already halted: answer without touching the core.
                                    state        <= RESP;
                                    rsp_valid_o  <= 1'b1;
                                    rsp_status_o <= ST_OK;
                                end else begin
                                    state          <= HALT_WAIT;
                                    cpu_halt_req_o <= 1'b1;
                                    cnt            <= LOAD_ACK;
                                end
                            end
                            OP_RUN: begin
                                if (!cpu_halt_status_i) begin
                                    // Already running: answer without touching the core.
                                    state        <= RESP;
                                    rsp_valid_o  <= 1'b1;
                                    rsp_status_o <= ST_OK;
                                end else begin
                                    state         <= RUN_WAIT;
                                    cpu_run_req_o <= 1'b1;
                                    cnt           <= LOAD_ACK;
                                end
                            end
                            OP_NMI: begin
                                state     <= NMI_HI;
                                nmi_int_o <= 1'b1;
                                cnt       <= LOAD_HOLD;
                            end
                            default: begin
                                state        <= RESP;
                                rsp_valid_o  <= 1'b1;
                                rsp_status_o <= ST_ILLEGAL;
                            end
                        endcase
                    end
                end

                HALT_WAIT: begin
                    // Ack is checked first so it wins over a same-cycle timeout.
                    if (cpu_halt_ack_i) begin
                        state          <= RESP;
                        cpu_halt_req_o <= 1'b0;
                        rsp_valid_o    <= 1'b1;
                        rsp_status_o   <= ST_OK;
                    end else if (cnt_last) begin
                        state          <= RESP;
                        cpu_halt_req_o <= 1'b0;
                        rsp_valid_o    <= 1'b1;
                        rsp_status_o   <= ST_TIMEOUT;
                    end else begin
                        cnt <= cnt_dec;
                    end
                end

                RUN_WAIT: begin
                    if (cpu_run_ack_i) begin
                        state         <= RESP;
                        cpu_run_req_o <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_status_o  <= ST_OK;
                    end else if (cnt_last) begin
                        state         <= RESP;
                        cpu_run_req_o <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_status_o  <= ST_TIMEOUT;
                    end else begin
                        cnt <= cnt_dec;
                    end
                end

                NMI_HI: begin
                    if (cnt_last) begin
                        state     <= NMI_LO;
                        nmi_int_o <= 1'b0;
                        cnt       <= LOAD_GAP;
                    end else begin
                        cnt <= cnt_dec;
                    end
                end

                NMI_LO: begin
                    // The low gap is part of the command, so the core always
                    // sees the minimum low time before another NMI can start.
                    if (cnt_last) begin
                        state        <= RESP;
                        rsp_valid_o  <= 1'b1;
                        rsp_status_o <= ST_OK;
                    end else begin
                        cnt <= cnt_dec;
                    end
                end

                RESP: begin
                    state       <= IDLE;
                    cmd_ready_o <= 1'b1;
                end

                default: begin
                    state          <= IDLE;
                    cmd_ready_o    <= 1'b0;
                    cpu_halt_req_o <= 1'b0;
                    cpu_run_req_o  <= 1'b0;
                    nmi_int_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_guineveer_halt_ctrl.sv
// ----------------------------------------------------------------------------
// tb_guineveer_halt_ctrl
// Directed and randomized commands against guineveer_halt_ctrl with
// ACK_TIMEOUT=8 and default NMI shaping. Each command's expected waveform is
// derived from its op, the core halt status and the ack delay.
// ----------------------------------------------------------------------------
module tb_guineveer_halt_ctrl;

    localparam int T = 8;
    localparam int H = 2;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic       rsp_valid;
    logic [1:0] rsp_status;
    logic       halt_req;
    logic       halt_ack = 1'b0;
    logic       halt_status = 1'b0;
    logic       run_req;
    logic       run_ack = 1'b0;
    logic       nmi;
    logic       core_halted;

    int checks = 0;
    int failures = 0;
    bit cur_hs = 1'b0;

    guineveer_halt_ctrl #(
        .ACK_TIMEOUT(T),
        .NMI_HOLD   (H),
        .NMI_GAP    (G)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cmd_valid_i      (cmd_valid),
        .cmd_ready_o      (cmd_ready),
        .cmd_op_i         (cmd_op),
        .rsp_valid_o      (rsp_valid),
        .rsp_status_o     (rsp_status),
        .cpu_halt_req_o   (halt_req),
        .cpu_halt_ack_i   (halt_ack),
        .cpu_halt_status_i(halt_status),
        .cpu_run_req_o    (run_req),
        .cpu_run_ack_i    (run_ack),
        .nmi_int_o        (nmi),
        .core_halted_o    (core_halted)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Outputs expected while nothing is in flight.
    task automatic chk_quiet(input string tag, input bit ready_exp);
        chk({tag, "_ready"}, cmd_ready, ready_exp);
        chk({tag, "_rsp"}, rsp_valid, 1'b0);
        chk({tag, "_hreq"}, halt_req, 1'b0);
        chk({tag, "_rreq"}, run_req, 1'b0);
        chk({tag, "_nmi"}, nmi, 1'b0);
    endtask

    // Idle cycles with random acks and no command: nothing may react.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cmd_valid = 1'b0;
            halt_ack  = 1'($urandom_range(0, 1));
            run_ack   = 1'($urandom_range(0, 1));
            step();
            chk_quiet("idle", 1'b1);
        end
        halt_ack = 1'b0;
        run_ack  = 1'b0;
    endtask

    // One command. d = number of request-high cycles after which the core
    // acks (the ack is sampled on the d-th edge after the request rises).
    task automatic run_txn(input int op, input bit hs, input int d);
        bit wait_h, wait_r;
        int len, rsp_k, hreq_len, rreq_len, nmi_len;
        logic [1:0] exp_stat;

        wait_h   = (op == 0) && !hs;
        wait_r   = (op == 1) && hs;
        hreq_len = 0;
        rreq_len = 0;
        nmi_len  = 0;
        if (wait_h || wait_r) begin
            len      = (d < T) ? d : T;
            rsp_k    = len + 1;
            exp_stat = (d <= T) ? 2'd0 : 2'd1;
            if (wait_h) hreq_len = len;
            else        rreq_len = len;
        end else if (op == 2) begin
            nmi_len  = H;
            rsp_k    = H + G + 1;
            exp_stat = 2'd0;
        end else begin
            rsp_k    = 1;
            exp_stat = (op == 3) ? 2'd2 : 2'd0;
        end

        chk("ready_before_cmd", cmd_ready, 1'b1);
        halt_status = hs;
        cur_hs      = hs;
        cmd_op      = 2'(op);
        cmd_valid   = 1'b1;
        halt_ack    = 1'($urandom_range(0, 1));
        run_ack     = 1'($urandom_range(0, 1));

        for (int k = 1; k <= rsp_k + 1; k++) begin
            step();
            chk("halt_req", halt_req, (k <= hreq_len));
            chk("run_req", run_req, (k <= rreq_len));
            chk("req_exclusive", halt_req & run_req, 1'b0);
            chk("nmi", nmi, (k <= nmi_len));
            chk("rsp_valid", rsp_valid, (k == rsp_k));
            if (k == rsp_k) chk("rsp_status", rsp_status, exp_stat);
            chk("cmd_ready", cmd_ready, (k == rsp_k + 1));
            chk("core_halted", core_halted, hs);

            // Stimulus for the next edge: busy-time valid and op noise must
            // be ignored; only the matching ack in a wait may complete it.
            cmd_valid = (k < rsp_k + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd_op    = 2'($urandom_range(0, 3));
            halt_ack  = wait_h ? (k >= d) : 1'($urandom_range(0, 1));
            run_ack   = wait_r ? (k >= d) : 1'($urandom_range(0, 1));
        end
        halt_ack = 1'b0;
        run_ack  = 1'b0;
    endtask

    int d_ops[10] = '{0, 0, 0, 1, 1, 2, 2, 3, 0, 1};
    int d_hs [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 1};
    int d_dly[10] = '{5, 9, 8, 3, 1, 1, 1, 1, 1, 8};

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        step();
        chk_quiet("reset", 1'b0);
        chk("reset_core_halted", core_halted, 1'b0);
        rst = 1'b0;
        step();
        chk_quiet("post_reset", 1'b1);

        // Directed: halt ack@5, halt timeout, ack on the timeout cycle,
        // run ack@3, run shortcut, back-to-back NMIs, reserved op,
        // halt shortcut, run ack exactly at timeout.
        for (int i = 0; i < 10; i++) begin
            run_txn(d_ops[i], d_hs[i][0], d_dly[i]);
            if (i == 6) idle(3);
        end

        // Randomized commands
        for (int i = 0; i < 60; i++) begin
            run_txn($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(1, T + 3));
            idle($urandom_range(0, 2));
        end

        // Reset in the middle of a halt wait
        halt_status = 1'b0;
        cmd_op      = 2'd0;
        cmd_valid   = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("mid_halt_req", halt_req, 1'b1);
        step();
        chk("mid_halt_req2", halt_req, 1'b1);
        rst = 1'b1;
        step();
        chk_quiet("mid_reset", 1'b0);
        step();
        chk_quiet("mid_reset_hold", 1'b0);
        rst = 1'b0;
        step();
        chk_quiet("mid_reset_release", 1'b1);
        step();
        chk_quiet("mid_reset_after", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
